// File: rtl/axis_packet_fifo_if.sv
// AXI4-Stream beat channel (data, last, valid, ready) shared by the FIFO's
// input and output sides.
interface axis_packet_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (
    output data,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/axis_packet_fifo.sv
// Synchronous AXI4-Stream FIFO with last sideband, occupancy count and
// almost-full/almost-empty flags. Define AXIS_PACKET_FIFO_STORE_FORWARD_EN for packet mode.
module axis_packet_fifo #(
  parameter int DATA_WIDTH         = 16,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  axis_packet_fifo_if.slave        s_axis,
  axis_packet_fifo_if.master       m_axis,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] AF_LVL = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL = CW'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [CW-1:0]       wptr_q, rptr_q, wptr_d, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                almost_full_q, almost_empty_q;
  logic                empty, full, s_ready, m_valid, wr_en, rd_en;
  logic [DATA_WIDTH:0] head;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign s_ready = ~full & ~reset;
  assign wr_en   = s_axis.valid & s_ready;
  assign rd_en   = m_valid & m_axis.ready;
  assign head    = mem_q[rptr_q[AW-1:0]];

`ifdef AXIS_PACKET_FIFO_STORE_FORWARD_EN
  logic [CW-1:0] pkt_q, pkt_d;

  // Full overrides the packet gate so packets longer than DEPTH cannot deadlock.
  assign m_valid = ~empty & ((pkt_q != '0) | full);

  always_comb begin
    pkt_d = pkt_q;
    if ((wr_en && s_axis.last) && !(rd_en && head[DATA_WIDTH]))
      pkt_d = pkt_q + CW'(1);
    else if (!(wr_en && s_axis.last) && (rd_en && head[DATA_WIDTH]))
      pkt_d = pkt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end
`else
  assign m_valid = ~empty;
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + CW'(1);
    if (rd_en) rptr_d = rptr_q + CW'(1);
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      almost_full_q  <= (count_d >= AF_LVL);
      almost_empty_q <= (count_d <= AE_LVL);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {s_axis.last, s_axis.data};
  end

  assign s_axis.ready = s_ready;
  assign m_axis.valid = m_valid;
  assign m_axis.data  = head[DATA_WIDTH-1:0];
  assign m_axis.last  = head[DATA_WIDTH];
  assign count        = count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

endmodule
